// File: rtl/pika_risc_core.sv
// Single-cycle RV32I core: one instruction fetched, executed and committed per clock.
// Instruction and data memories are external with combinational reads.
module pika_risc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] dmem_addr,
  output logic        dmem_write_en,
  output logic [31:0] dmem_val_out,
  input  logic [31:0] dmem_val_in
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  function automatic logic [DATA_W-1:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [DATA_W-1:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [DATA_W-1:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       alt;

  assign opcode = imem_data[6:0];
  assign rd     = imem_data[11:7];
  assign funct3 = imem_data[14:12];
  assign rs1    = imem_data[19:15];
  assign rs2    = imem_data[24:20];
  assign alt    = imem_data[30];

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_store  = (opcode == OP_STORE) && (funct3 == 3'b010);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);

  logic [DATA_W-1:0]        rs1_val, rs2_val;
  logic signed [DATA_W-1:0] rs1_s, rs2_s;

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign rs1_s   = rs1_val;
  assign rs2_s   = rs2_val;

  logic [DATA_W-1:0] imm;

  always_comb begin
    imm = imm_i(imem_data);
    if (is_store) imm = imm_s(imem_data);
    else if (is_lui || is_auipc) imm = imm_u(imem_data);
  end

  // Every non-ALU instruction reuses the adder: address, JALR target, LUI, AUIPC.
  logic [DATA_W-1:0]        op_a, op_b, alu_res;
  logic signed [DATA_W-1:0] op_a_s, op_b_s, sra_res;
  logic [2:0]               alu_f3;
  logic [4:0]               shamt;

  assign op_a    = is_auipc ? pc : (is_lui ? '0 : rs1_val);
  assign op_b    = is_r ? rs2_val : imm;
  assign op_a_s  = op_a;
  assign op_b_s  = op_b;
  assign alu_f3  = (is_r || is_i) ? funct3 : 3'b000;
  assign shamt   = op_b[4:0];
  assign sra_res = op_a_s >>> shamt;

  always_comb begin
    alu_res = '0;
    case (alu_f3)
      3'b000: alu_res = (is_r && alt) ? op_a - op_b : op_a + op_b;
      3'b001: alu_res = op_a << shamt;
      3'b010: alu_res = {{(DATA_W-1){1'b0}}, op_a_s < op_b_s};
      3'b011: alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = alt ? sra_res : op_a >> shamt;
      3'b110: alu_res = op_a | op_b;
      3'b111: alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  logic taken;

  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:  taken = (rs1_val == rs2_val);
        3'b001:  taken = (rs1_val != rs2_val);
        3'b100:  taken = (rs1_s < rs2_s);
        3'b101:  taken = (rs1_s >= rs2_s);
        default: taken = 1'b0;
      endcase
    end
  end

  logic [DATA_W-1:0] pc_plus4, next_pc, wb_val;
  logic              rf_we;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)      next_pc = pc + imm_j(imem_data);
    else if (is_jalr) next_pc = {alu_res[DATA_W-1:1], 1'b0};
    else if (taken)   next_pc = pc + imm_b(imem_data);
  end

  assign rf_we  = is_r || is_i || is_load || is_jal || is_jalr || is_lui || is_auipc;
  assign wb_val = is_load ? dmem_val_in : ((is_jal || is_jalr) ? pc_plus4 : alu_res);

  assign imem_addr     = pc;
  assign dmem_addr     = alu_res;
  assign dmem_val_out  = rs2_val;
  assign dmem_write_en = is_store && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rf_we && (rd != 5'd0)) regs[rd] <= wb_val;
    end
  end

endmodule

// File: tb/tb_pika_risc_core.sv
// Bench for pika_risc_core: directed test-plan steps plus random instructions
// checked against an instruction-level model of RV32I.
module tb_pika_risc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_val_out, dmem_val_in;
  logic        dmem_write_en;

  logic [31:0] mem [256];
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  assign dmem_val_in = mem[dmem_addr[9:2]];

  always #5 clk = ~clk;

  pika_risc_core dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_write_en(dmem_write_en),
    .dmem_val_out(dmem_val_out), .dmem_val_in(dmem_val_in)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic sub_ok,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    logic [31:0] r;
    sa = a; sb = b;
    sr = sa >>> b[4:0];
    case (f3)
      3'd0: if (sub_ok && alt) r = a - b; else r = a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: if (alt) r = sr; else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Architectural effect of one instruction on the model state.
  task automatic model(input logic [31:0] ins, output logic [31:0] npc, output logic wr,
                       output logic [31:0] wval, output logic st,
                       output logic [31:0] saddr, output logic [31:0] sval);
    logic [31:0] a, b, ii, si, bi, ji, ui, ea;
    logic signed [31:0] sa, sb;
    logic [2:0] f3;
    f3 = ins[14:12];
    a  = m_rf[ins[19:15]];
    b  = m_rf[ins[24:20]];
    sa = a; sb = b;
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    ui = {ins[31:12], 12'b0};
    npc = m_pc + 32'd4; wr = 1'b0; wval = '0; st = 1'b0; saddr = '0; sval = '0;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; wval = alu(f3, ins[30], 1'b1, a, b); end
      7'h13: begin wr = 1'b1; wval = alu(f3, ins[30], 1'b0, a, ii); end
      7'h03: if (f3 == 3'd2) begin ea = a + ii; wr = 1'b1; wval = mem[ea[9:2]]; end
      7'h23: if (f3 == 3'd2) begin st = 1'b1; saddr = a + si; sval = b; end
      7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b) ||
                 (f3 == 3'd4 && sa < sb) || (f3 == 3'd5 && sa >= sb)) npc = m_pc + bi;
      7'h6F: begin wr = 1'b1; wval = m_pc + 32'd4; npc = m_pc + ji; end
      7'h67: begin wr = 1'b1; wval = m_pc + 32'd4; ea = a + ii; npc = {ea[31:1], 1'b0}; end
      7'h37: begin wr = 1'b1; wval = ui; end
      7'h17: begin wr = 1'b1; wval = m_pc + ui; end
      default: ;
    endcase
  endtask

  // Called just after a falling edge; returns what the DUT drove during the cycle.
  task automatic step(input logic [31:0] ins, output logic [31:0] o_addr,
                      output logic [31:0] o_val, output logic o_we);
    logic [31:0] npc, wval, saddr, sval;
    logic wr, st;
    imem_data = ins;
    #1;
    model(ins, npc, wr, wval, st, saddr, sval);
    o_addr = dmem_addr; o_val = dmem_val_out; o_we = dmem_write_en;
    check("pc", imem_addr, m_pc);
    check("write_en", {31'b0, dmem_write_en}, {31'b0, st});
    if (st) begin
      check("store_addr", dmem_addr, saddr);
      check("store_data", dmem_val_out, sval);
    end
    @(posedge clk);
    m_pc = npc;
    if (wr && ins[11:7] != 5'd0) m_rf[ins[11:7]] = wval;
    if (st) mem[saddr[9:2]] = sval;
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] ins);
    logic [31:0] a, v;
    logic w;
    step(ins, a, v, w);
  endtask

  // Registers are observed through the store-data port.
  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    logic [31:0] a, v;
    logic w;
    step(enc_s(12'h000, r, 5'd0), a, v, w);
    check(tag, v, exp);
  endtask

  task automatic do_reset(input logic [31:0] ins);
    reset = 1'b0;
    imem_data = ins;
    #1;
    check("reset_write_en", {31'b0, dmem_write_en}, 32'd0);
    @(posedge clk);
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_pc", imem_addr, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    int k;
    r   = $urandom();
    k   = $urandom_range(0, 13);
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    f3  = 3'($urandom_range(0, 7));
    imm = r[11:0];
    case (k)
      0, 1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      2, 3, 4: begin
        if (f3 == 3'd1) imm = {7'h00, r[4:0]};
        else if (f3 == 3'd5) imm = {(r[31] ? 7'h20 : 7'h00), r[4:0]};
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      5: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
      6, 7: return enc_s(imm, rs2, rs1);
      8: begin
        case (r[30:29])
          2'd0: f3 = 3'd0;
          2'd1: f3 = 3'd1;
          2'd2: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        return enc_b({r[24:13], 1'b0}, rs2, rs1, f3);
      end
      9:  return enc_j({r[31:12], 1'b0}, rd);
      10: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
      11: return {r[31:12], rd, 7'h37};
      12: return {r[31:12], rd, 7'h17};
      default: begin
        case (r[1:0])
          2'd0: f7 = 7'h00;
          2'd1: f7 = 7'h7F;
          2'd2: f7 = 7'h0B;
          default: f7 = 7'h2B;
        endcase
        return {r[31:7], f7};
      end
    endcase
  endfunction

  initial begin
    logic [31:0] sa, sv;
    logic sw;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = '0;
    reset = 1'b0;
    imem_data = NOP;

    do_reset(NOP);
    for (int i = 0; i < 3; i++) run(NOP);
    #1;
    check("pc_after_nops", imem_addr, 32'd12);
    check("nop_write_en", {31'b0, dmem_write_en}, 32'd0);

    run(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    run(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13));
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    run(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4));
    run(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5));
    run(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));
    chk_reg("add_x3", 5'd3, 32'd2);
    chk_reg("sub_x4", 5'd4, 32'hFFFF_FFF8);
    chk_reg("slt_x5", 5'd5, 32'd1);
    chk_reg("x0_zero", 5'd0, 32'd0);

    run(enc_i(12'h040, 5'd0, 3'd0, 5'd1, 7'h13));
    run(enc_i(12'h123, 5'd0, 3'd0, 5'd2, 7'h13));
    step(enc_s(12'd4, 5'd2, 5'd1), sa, sv, sw);
    check("sw_addr", sa, 32'h44);
    check("sw_data", sv, 32'h123);
    check("sw_we", {31'b0, sw}, 32'd1);
    run(enc_i(12'd4, 5'd1, 3'd2, 5'd3, 7'h03));
    chk_reg("lw_x3", 5'd3, 32'h123);

    do_reset(NOP);
    for (int i = 0; i < 4; i++) run(NOP);
    run(enc_b(13'd8, 5'd0, 5'd0, 3'd0));
    #1 check("beq_taken", imem_addr, 32'h18);
    run(enc_b(13'd8, 5'd0, 5'd0, 3'd1));
    #1 check("bne_not_taken", imem_addr, 32'h1C);
    run(NOP);
    run(enc_j(21'd16, 5'd1));
    #1 check("jal_target", imem_addr, 32'h30);
    run(enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));
    #1 check("jalr_target", imem_addr, 32'h24);
    chk_reg("jal_link", 5'd1, 32'h24);

    for (int i = 0; i < 400; i++) run(rand_instr());
    for (int r = 1; r < 16; r++) run(enc_s(12'h000, 5'(r), 5'd0));

    do_reset(enc_s(12'd4, 5'd2, 5'd1));
    for (int r = 1; r < 32; r++) chk_reg("reg_cleared", 5'(r), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pika_risc_core.md
Name: pika_risc_core

Overview:
- Single-cycle 32-bit RISC-V (RV32I integer subset) processor core; the top-level CPU of the design.
- Fetches one instruction per clock from an external instruction memory.
- Executes the instruction and accesses an external data memory in the same cycle.
- Both memories are external, combinational-read, and byte-addressed with word-sized data.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NUM_REGS, 32, number of architectural registers (x0..x31)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- imem_addr  output  32  byte address of the instruction to fetch; equals the current PC
- imem_data  input  32  instruction word returned combinationally for imem_addr
- dmem_addr  output  32  data byte address; ALU result (rs1 + imm) for LW/SW, else ALU result
- dmem_write_en  output  1  high for the whole cycle of a SW; low otherwise
- dmem_val_out  output  32  store data (rs2 value); valid while dmem_write_en = 1
- dmem_val_in  input  32  load data returned combinationally for dmem_addr

Behaviour:
- State:
  - PC (32 bits).
  - 32x32 register file; x0 reads 0 and writes to x0 are discarded.
  - No other architectural state.
- Reset: if reset = 0 at a rising clk edge, then:
  - PC <= RESET_PC and all registers <= 0.
  - No register-file write or PC update from the current instruction.
  - dmem_write_en is forced to 0 combinationally while reset = 0.
- Single-cycle operation: each rising edge with reset = 1 commits exactly one instruction.
  - Register writeback and PC update occur at that edge.
  - imem_addr = PC combinationally.
- Supported instructions (standard RV32I encodings):
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LW, SW, BEQ, BNE, BLT, BGE, JAL, JALR, LUI, AUIPC.
- Arithmetic rules:
  - 32-bit two's complement; overflow wraps silently.
  - Shift amount = low 5 bits of the operand.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; result is 0 or 1.
  - Immediates are sign-extended per the RISC-V format.
- Next PC:
  - Default PC + 4.
  - Taken branch: PC + B-imm.
  - JAL: PC + J-imm.
  - JALR: (rs1 + I-imm) with bit 0 cleared.
  - JAL/JALR write PC + 4 to rd.
  - PC wraps modulo 2^32.
- Loads/stores:
  - LW writes dmem_val_in to rd.
  - SW drives dmem_addr, dmem_val_out and dmem_write_en = 1 for the full cycle; the memory captures the value by the next edge.
  - Low two address bits are passed through unmodified; alignment is the memory's concern.
- Outputs on non-store cycles: dmem_write_en = 0; dmem_addr and dmem_val_out are don't-care but deterministic.
- Unknown opcodes execute as NOP: PC + 4, no register or memory write.
- Same-cycle read/write of a register: reads return the old value; the write commits at the edge.
- Reset asserted mid-instruction aborts that instruction; a pending SW is suppressed.

Test Plan:
- Reset: hold reset = 0 for 1 edge, release -> imem_addr = 0; after 3 edges with NOPs (0x00000013), imem_addr = 12 and dmem_write_en stays 0.
- ALU: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLT x5,x2,x1 -> x3 = 2, x4 = 0xFFFFFFF8, x5 = 1; ADDI x0,x0,7 leaves x0 = 0.
- Memory: ADDI x1,x0,0x40; ADDI x2,x0,0x123; SW x2,4(x1) -> in the SW cycle, dmem_addr = 0x44, dmem_val_out = 0x123, dmem_write_en = 1; then LW x3,4(x1) -> x3 = 0x123.
- Branches: BEQ taken with equal operands at PC = 0x10, offset +8 -> next imem_addr = 0x18; BNE not taken -> PC + 4.
- Jumps: JAL x1,+16 at PC = 0x20 -> PC = 0x30, x1 = 0x24; JALR x0,0(x1) -> PC = 0x24.
- Reset mid-run: assert reset = 0 during a SW cycle -> dmem_write_en = 0, PC returns to 0, all registers read 0.
